// File: rtl/line_fill_responder_pkg.sv
// Shared cache constants and responder FSM state encoding.
package line_fill_responder_pkg;

  localparam int LFR_ADDRESS_WIDTH   = 32;
  localparam int LFR_DATA_WIDTH      = 32;
  localparam int LFR_LINE_SIZE_BYTES = 64;
  localparam int LFR_OFFSET_BITS     = 6;
  localparam int LFR_MEM_LINES       = 1024;
  localparam int LFR_READ_LATENCY    = 4;

  localparam int LFR_WORDS_PER_LINE  = LFR_LINE_SIZE_BYTES * 8 / LFR_DATA_WIDTH;
  localparam int LFR_BEAT_W          = $clog2(LFR_WORDS_PER_LINE);
  localparam int LFR_INDEX_W         = $clog2(LFR_MEM_LINES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_WR_ACK   = 3'd4
  } lfr_state_t;

endpackage

// File: rtl/line_fill_responder_ram.sv
// Backing store: single-port synchronous RAM, one-cycle registered read.
module line_store_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 14
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write on request; always register the addressed word for the read path.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/line_fill_responder.sv
// Memory-side line responder: serves one line fetch or one dirty writeback
// at a time, streaming WORDS_PER_LINE beats to/from the backing store.
module line_fill_responder
  import line_fill_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = LFR_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = LFR_DATA_WIDTH,
  parameter int LINE_SIZE_BYTES = LFR_LINE_SIZE_BYTES,
  parameter int OFFSET_BITS     = LFR_OFFSET_BITS,
  parameter int MEM_LINES       = LFR_MEM_LINES,
  parameter int READ_LATENCY    = LFR_READ_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_last,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_done
);

  localparam int WPL    = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int BEAT_W = $clog2(WPL);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int RAM_AW = IDX_W + BEAT_W;
  localparam int LAT_W  = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam int ADDR_HI = OFFSET_BITS + IDX_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WPL - 1);

  lfr_state_t         r_state, w_state_nxt;
  logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
  logic [LAT_W-1:0]   r_lat_cnt, w_lat_nxt;
  logic [IDX_W-1:0]   r_line;
  logic [IDX_W-1:0]   w_req_idx;
  logic [RAM_AW-1:0]  w_ram_addr;
  logic               w_ram_we;
  logic               w_accept;
  logic               w_unused_addr;

  // Offset and upper address bits do not select anything: lines wrap modulo MEM_LINES.
  assign w_req_idx     = req_addr[OFFSET_BITS +: IDX_W];
  assign w_unused_addr = ^{req_addr[ADDRESS_WIDTH-1:ADDR_HI], req_addr[OFFSET_BITS-1:0]};

  assign req_ready = (r_state == ST_IDLE) && rst;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == ST_RD_BURST);
  assign rsp_last  = rsp_valid && (r_beat == LAST_BEAT);
  assign wr_ready  = (r_state == ST_WR_BURST);
  assign wr_done   = (r_state == ST_WR_ACK);

  // Control state: FSM, beat counter and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_lat_cnt <= w_lat_nxt;
    end
  end

  // Line index captured on accept; data path, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line <= w_req_idx;
    end
  end

  // Next-state, beat and latency sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_beat_nxt = '0;
          if (req_we) begin
            w_state_nxt = ST_WR_BURST;
          end else if (READ_LATENCY == 0) begin
            w_state_nxt = ST_RD_BURST;
          end else begin
            w_state_nxt = ST_RD_WAIT;
            w_lat_nxt   = LAT_W'(READ_LATENCY);
          end
        end
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == LAT_W'(1)) begin
          w_state_nxt = ST_RD_BURST;
        end else begin
          w_lat_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
      ST_RD_BURST: begin
        if (rsp_ready) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_WR_BURST: begin
        if (wr_valid) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = ST_WR_ACK;
          end
        end
      end
      ST_WR_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM address: the word that must be on rsp_data next cycle is fetched now,
  // so a handshake prefetches beat+1 and a stall re-reads the current beat.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_addr = {r_line, r_beat};
    case (r_state)
      ST_IDLE:     w_ram_addr = {w_req_idx, {BEAT_W{1'b0}}};
      ST_RD_WAIT:  w_ram_addr = {r_line, {BEAT_W{1'b0}}};
      ST_RD_BURST: w_ram_addr = {r_line, w_beat_nxt};
      ST_WR_BURST: begin
        w_ram_addr = {r_line, r_beat};
        w_ram_we   = wr_valid;
      end
      default:     w_ram_addr = {r_line, r_beat};
    endcase
  end

  line_store_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (RAM_AW)
  ) u_store (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (wr_data),
    .o_rdata (rsp_data)
  );

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed + randomized bench for line_fill_responder with a line-array model.
module tb_line_fill_responder;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int WPL       = 16;
  localparam int MEM_LINES = 1024;
  localparam int RLAT      = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model_mem [MEM_LINES*WPL];

  always #5 clk = ~clk;

  line_fill_responder #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .LINE_SIZE_BYTES (64),
    .OFFSET_BITS     (6),
    .MEM_LINES       (MEM_LINES),
    .READ_LATENCY    (RLAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_done   (wr_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int line_base(input logic [31:0] addr);
    return int'((addr / 64) % MEM_LINES) * WPL;
  endfunction

  // Writeback of one line; hold=1 keeps wr_valid high, else random gaps.
  task automatic do_write(input logic [31:0] addr, input logic [DW-1:0] d [WPL], input bit hold);
    int k = 0;
    int cyc = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
    check("wr_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    while (k < WPL && cyc < 400) begin
      wr_valid  = hold ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data   = d[k];
      rsp_ready = 1'($urandom_range(0, 1));
      check("wr_ready_burst", {31'd0, wr_ready}, 32'd1);
      check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("wr_no_done", {31'd0, wr_done}, 32'd0);
      @(posedge clk);
      if (wr_valid) k++;
      cyc++;
      @(negedge clk);
    end
    check("wr_beats", k, WPL);
    wr_valid = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < WPL; i++) model_mem[line_base(addr) + i] = d[i];
    check("wr_done_pulse", {31'd0, wr_done}, 32'd1);
    check("wr_ack_ready", {31'd0, wr_ready}, 32'd0);
    check("wr_ack_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("wr_done_drop", {31'd0, wr_done}, 32'd0);
    check("wr_idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Line fetch. mode 0: always ready, 1: toggling, 2: random.
  // hold keeps req_valid asserted; rst_beat >= 0 resets while that beat is presented.
  task automatic do_read(input logic [31:0] addr, input int mode, input bit hold, input int rst_beat);
    int k = 0;
    int cyc = 0;
    int base;
    bit rr;
    bit stalled = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    base = line_base(addr);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    check("rd_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int i = 0; i < RLAT; i++) begin
      check("rd_latency_idle", {31'd0, rsp_valid}, 32'd0);
      check("rd_wait_busy", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    while (k < WPL && cyc < 400) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2) == 0;
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rsp_ready = rr;
      wr_valid  = 1'($urandom_range(0, 1));
      wr_data   = $urandom;
      check("rd_valid", {31'd0, rsp_valid}, 32'd1);
      check("rd_data", rsp_data, model_mem[base + k]);
      check("rd_last", {31'd0, rsp_last}, {31'd0, k == WPL - 1});
      check("rd_busy", {31'd0, req_ready}, 32'd0);
      check("rd_no_wr_ready", {31'd0, wr_ready}, 32'd0);
      if (stalled) begin
        check("rd_stall_data", rsp_data, prev_data);
        check("rd_stall_last", {31'd0, rsp_last}, {31'd0, prev_last});
      end
      if (k == rst_beat) begin
        #1 rst = 1'b0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0; rsp_ready = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        check("rst_release_valid", {31'd0, rsp_valid}, 32'd0);
        return;
      end
      prev_data = rsp_data;
      prev_last = rsp_last;
      stalled   = !rr;
      @(posedge clk);
      if (rr) k++;
      cyc++;
      @(negedge clk);
    end
    check("rd_beats", k, WPL);
    rsp_ready = 1'b0; wr_valid = 1'b0;
    check("rd_end_ready", {31'd0, req_ready}, 32'd1);
    check("rd_end_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d [WPL];
    logic [31:0] a;
    logic [31:0] a2;

    // Reset state
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_last", {31'd0, rsp_last}, 32'd0);
    check("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("reset_wr_done", {31'd0, wr_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Line 5 writeback, wr_valid held high
    for (int i = 0; i < WPL; i++) d[i] = 32'h500 + i;
    do_write(32'h0000_0140, d, 1'b1);

    // Fetch line 5, always ready
    do_read(32'h0000_0140, 0, 1'b0, -1);

    // Fetch line 5 with rsp_ready toggling
    do_read(32'h0000_0140, 1, 1'b0, -1);

    // Aliased writeback, then fetch through the base address
    for (int i = 0; i < WPL; i++) d[i] = 32'hA5_0000 + (i * 3);
    do_write(32'h0001_0140, d, 1'b0);
    do_read(32'h0000_0140, 0, 1'b0, -1);

    // Request held high across a burst; back-to-back accept
    do_read(32'h0000_0140, 2, 1'b1, -1);
    do_read(32'h0000_0140, 0, 1'b0, -1);

    // Reset at beat 7, then a fresh read
    do_read(32'h0000_0140, 0, 1'b0, 7);
    do_read(32'h0000_0140, 1, 1'b0, -1);

    // Randomized lines, addresses and handshakes
    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      for (int i = 0; i < WPL; i++) d[i] = $urandom;
      do_write(a, d, 1'b0);
      a2 = ((a / 64) % MEM_LINES) * 64 + ($urandom & 32'hFFFF_0000) + ($urandom % 64);
      do_read(a2, 2, 1'b0, -1);
      if (t % 2 == 0) do_read(a, 0, 1'b0, -1);
    end

    // Line 5 must be untouched unless a random line hit it
    do_read(32'h0000_0140, 0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
